// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit -- RV64 writeback stage, sole writer of the GPR register file.
//
// Latches the MEM-stage result into the MEM/WB register on posedge, formats
// load data (byte/half/word/double, signed/unsigned) and drives the register
// file write port for the whole following cycle. The register file commits on
// the falling edge, so decode sees the new value without a WB->ID bypass.
//
// Optional feature macro: WB_INSTRET_EN (retired-instruction counter). When
// undefined no counter is built and instret is tied to zero.
//
// Ports:
//   clk, rst_n        clock (posedge) / asynchronous active-low reset
//   stall, flush      hold / bubble the MEM/WB register (flush wins)
//   mem_valid         MEM stage holds a real instruction
//   mem_reg_write     instruction writes rd
//   mem_rd            destination register index
//   mem_is_load       select load path instead of ALU result
//   mem_funct3        load size/sign (RV64 encoding)
//   mem_addr_lo       low address bits of the load
//   mem_alu_result    ALU/CSR/link result
//   mem_load_data     raw aligned doubleword from data memory
//   rf_we             register-file write enable
//   rf_write_num      register-file write index
//   rf_in_value       register-file write data
//   fwd_valid         WB holds a forwardable result (== rf_we)
//   wb_illegal        WB holds a load with funct3 = 3'b111
//   instret           retired-instruction count
// ---------------------------------------------------------------------------
module wb_unit #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic                mem_reg_write,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_is_load,
    input  logic [2:0]          mem_funct3,
    input  logic [2:0]          mem_addr_lo,
    input  logic [XLEN-1:0]     mem_alu_result,
    input  logic [XLEN-1:0]     mem_load_data,
    output logic                rf_we,
    output logic [REG_BITS-1:0] rf_write_num,
    output logic [XLEN-1:0]     rf_in_value,
    output logic                fwd_valid,
    output logic                wb_illegal,
    output logic [63:0]         instret
);

    // MEM/WB pipeline register
    logic                r_valid;
    logic                r_reg_write;
    logic [REG_BITS-1:0] r_rd;
    logic                r_is_load;
    logic [2:0]          r_funct3;
    logic [2:0]          r_addr_lo;
    logic [XLEN-1:0]     r_alu_result;
    logic [XLEN-1:0]     r_load_data;

    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_word;
    logic [XLEN-1:0]     w_result;
    logic                w_illegal;

    // Flush only clears valid; the payload fields are don't-care in a bubble
    // and are simply left holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_is_load    <= 1'b0;
            r_funct3     <= '0;
            r_addr_lo    <= '0;
            r_alu_result <= '0;
            r_load_data  <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
        end else if (!stall) begin
            r_valid      <= mem_valid;
            r_reg_write  <= mem_reg_write;
            r_rd         <= mem_rd;
            r_is_load    <= mem_is_load;
            r_funct3     <= mem_funct3;
            r_addr_lo    <= mem_addr_lo;
            r_alu_result <= mem_alu_result;
            r_load_data  <= mem_load_data;
        end
    end

    // Lane extraction; the unused low address bits are dropped, which aligns
    // misaligned accesses down without trapping.
    assign w_byte = r_load_data[{r_addr_lo, 3'b000} +: 8];
    assign w_half = r_load_data[{r_addr_lo[2:1], 4'b0000} +: 16];
    assign w_word = r_load_data[{r_addr_lo[2], 5'b00000} +: 32];

    always_comb begin
        w_result = r_alu_result;
        if (r_is_load) begin
            case (r_funct3)
                3'd0:    w_result = {{(XLEN-8){w_byte[7]}}, w_byte};
                3'd4:    w_result = {{(XLEN-8){1'b0}}, w_byte};
                3'd1:    w_result = {{(XLEN-16){w_half[15]}}, w_half};
                3'd5:    w_result = {{(XLEN-16){1'b0}}, w_half};
                3'd2:    w_result = {{(XLEN-32){w_word[31]}}, w_word};
                3'd6:    w_result = {{(XLEN-32){1'b0}}, w_word};
                3'd3:    w_result = r_load_data;
                default: w_result = '0;
            endcase
        end
    end

    assign w_illegal    = r_valid & r_is_load & (r_funct3 == 3'b111);
    assign rf_we        = r_valid & r_reg_write & (r_rd != '0) & ~w_illegal;
    assign fwd_valid    = rf_we;
    assign wb_illegal   = w_illegal;
    assign rf_write_num = r_rd;
    assign rf_in_value  = w_result;

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    // Retire the outgoing entry when the register accepts a new one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (!flush && !stall && r_valid && !w_illegal) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
module tb_wb_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [2:0]  mem_addr_lo;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_load_data;
    logic        rf_we;
    logic [4:0]  rf_write_num;
    logic [63:0] rf_in_value;
    logic        fwd_valid;
    logic        wb_illegal;
    logic [63:0] instret;

    int checks   = 0;
    int failures = 0;

    wb_unit #(.XLEN(64), .REG_BITS(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_is_load   (mem_is_load),
        .mem_funct3    (mem_funct3),
        .mem_addr_lo   (mem_addr_lo),
        .mem_alu_result(mem_alu_result),
        .mem_load_data (mem_load_data),
        .rf_we         (rf_we),
        .rf_write_num  (rf_write_num),
        .rf_in_value   (rf_in_value),
        .fwd_valid     (fwd_valid),
        .wb_illegal    (wb_illegal),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic        ld;
        logic [2:0]  f3;
        logic [2:0]  a;
        logic [63:0] alu;
        logic [63:0] data;
        logic        e_we;
        logic [63:0] e_val;
        logic        e_ill;
        logic        chk_val;
    } vec_t;

    localparam logic [63:0] LDATA = 64'h8877_6655_4433_2211;

`ifdef WB_INSTRET_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                         input logic ld, input logic [2:0] f3, input logic [2:0] a,
                         input logic [63:0] alu, input logic [63:0] data);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_rd         = rd;
        mem_is_load    = ld;
        mem_funct3     = f3;
        mem_addr_lo    = a;
        mem_alu_result = alu;
        mem_load_data  = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
    endtask

    // Reference formatting: shift the wanted lane down, then sign/zero extend.
    function automatic logic [63:0] ref_result(input logic ld, input logic [2:0] f3,
                                               input logic [2:0] a, input logic [63:0] alu,
                                               input logic [63:0] data);
        int unsigned off;
        logic [63:0] sh;
        logic signed [63:0] s;
        if (!ld) return alu;
        case (f3)
            3'd0, 3'd4: off = int'(a);
            3'd1, 3'd5: off = int'(a) / 2 * 2;
            3'd2, 3'd6: off = int'(a) / 4 * 4;
            default:    off = 0;
        endcase
        sh = data >> (off * 8);
        case (f3)
            3'd0: begin s = signed'(sh << 56); return 64'(s >>> 56); end
            3'd1: begin s = signed'(sh << 48); return 64'(s >>> 48); end
            3'd2: begin s = signed'(sh << 32); return 64'(s >>> 32); end
            3'd4: return sh & 64'hFF;
            3'd5: return sh & 64'hFFFF;
            3'd6: return sh & 64'hFFFF_FFFF;
            3'd3: return data;
            default: return 64'd0;
        endcase
    endfunction

    vec_t vecs[$];

    // Model state for random phase
    logic        m_v, m_rw, m_ld;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3, m_a;
    logic [63:0] m_alu, m_data;
    logic [63:0] m_cnt;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);

        // ---------------- reset state
        step();
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_fwd", 64'(fwd_valid), 64'd0);
        chk("rst_ill", 64'(wb_illegal), 64'd0);
        chk("rst_num", 64'(rf_write_num), 64'd0);
        chk("rst_val", rf_in_value, 64'd0);
        chk("rst_instret", instret, 64'd0);
        #2 rst_n = 1'b1;

        // ---------------- table-driven vectors
        vecs.push_back('{"alu_rd5", 1,1,5'd5, 0,3'd0,3'd0, 64'h1234, LDATA, 1, 64'h1234, 0, 1});
        vecs.push_back('{"alu_rd0", 1,1,5'd0, 0,3'd0,3'd0, 64'h1234, LDATA, 0, 64'h1234, 0, 1});
        vecs.push_back('{"lb_a7",   1,1,5'd7, 1,3'd0,3'd7, 64'h0, LDATA, 1, 64'hFFFF_FFFF_FFFF_FF88, 0, 1});
        vecs.push_back('{"lbu_a7",  1,1,5'd7, 1,3'd4,3'd7, 64'h0, LDATA, 1, 64'h88, 0, 1});
        vecs.push_back('{"lh_a6",   1,1,5'd8, 1,3'd1,3'd6, 64'h0, LDATA, 1, 64'hFFFF_FFFF_FFFF_8877, 0, 1});
        vecs.push_back('{"lwu_a4",  1,1,5'd9, 1,3'd6,3'd4, 64'h0, LDATA, 1, 64'h0000_0000_8877_6655, 0, 1});
        vecs.push_back('{"ld_a7",   1,1,5'd10,1,3'd3,3'd7, 64'h0, LDATA, 1, LDATA, 0, 1});
        vecs.push_back('{"lw_a0",   1,1,5'd11,1,3'd2,3'd0, 64'h0, LDATA, 1, 64'h0000_0000_4433_2211, 0, 1});
        vecs.push_back('{"lw_a5",   1,1,5'd12,1,3'd2,3'd5, 64'h0, LDATA, 1, 64'hFFFF_FFFF_8877_6655, 0, 1});
        vecs.push_back('{"lhu_a1",  1,1,5'd13,1,3'd5,3'd1, 64'h0, LDATA, 1, 64'h2211, 0, 1});
        vecs.push_back('{"lb_a2",   1,1,5'd14,1,3'd0,3'd2, 64'h0, LDATA, 1, 64'h33, 0, 1});
        vecs.push_back('{"illegal", 1,1,5'd15,1,3'd7,3'd0, 64'h0, LDATA, 0, 64'h0, 1, 0});
        vecs.push_back('{"no_rw",   1,0,5'd16,0,3'd0,3'd0, 64'h77, LDATA, 0, 64'h77, 0, 1});
        vecs.push_back('{"invalid", 0,1,5'd17,0,3'd0,3'd0, 64'h99, LDATA, 0, 64'h99, 0, 0});

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].rd, vecs[i].ld, vecs[i].f3,
                  vecs[i].a, vecs[i].alu, vecs[i].data);
            step();
            chk({vecs[i].name, "_we"}, 64'(rf_we), 64'(vecs[i].e_we));
            chk({vecs[i].name, "_fwd"}, 64'(fwd_valid), 64'(vecs[i].e_we));
            chk({vecs[i].name, "_ill"}, 64'(wb_illegal), 64'(vecs[i].e_ill));
            chk({vecs[i].name, "_num"}, 64'(rf_write_num), 64'(vecs[i].rd));
            if (vecs[i].chk_val)
                chk({vecs[i].name, "_val"}, rf_in_value, vecs[i].e_val);
        end

        // ---------------- stall 3 cycles, then flush with stall high
        drive(1'b1, 1'b1, 5'd9, 1'b0, 3'd0, 3'd0, 64'hABC, 64'd0);
        step();
        chk("stall_pre_we", 64'(rf_we), 64'd1);
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd21, 1'b0, 3'd0, 3'd0, 64'hDEAD, 64'd0);
        for (int unsigned k = 0; k < 3; k++) begin
            step();
            chk("stall_we", 64'(rf_we), 64'd1);
            chk("stall_num", 64'(rf_write_num), 64'd9);
            chk("stall_val", rf_in_value, 64'hABC);
        end
        flush = 1'b1;
        step();
        chk("flush_we", 64'(rf_we), 64'd0);
        chk("flush_fwd", 64'(fwd_valid), 64'd0);
        flush = 1'b0;
        stall = 1'b0;

        // ---------------- asynchronous reset mid-cycle
        drive(1'b1, 1'b1, 5'd3, 1'b0, 3'd0, 3'd0, 64'h55, 64'd0);
        step();
        chk("pre_async_we", 64'(rf_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we", 64'(rf_we), 64'd0);
        chk("async_fwd", 64'(fwd_valid), 64'd0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_we", 64'(rf_we), 64'd0);
        chk("post_rst_instret", instret, 64'd0);

        // ---------------- instret: 10 valid, 2 bubbles, 1 illegal
        for (int unsigned k = 0; k < 13; k++) begin
            if (k == 3 || k == 8)
                drive(1'b0, 1'b1, 5'd1, 1'b0, 3'd0, 3'd0, 64'd1, 64'd0);
            else if (k == 6)
                drive(1'b1, 1'b1, 5'd2, 1'b1, 3'd7, 3'd0, 64'd0, 64'd0);
            else
                drive(1'b1, 1'b1, 5'(k + 1), 1'b0, 3'd0, 3'd0, 64'(k), 64'd0);
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        step();
        chk("instret_10", instret, CNT_EN ? 64'd10 : 64'd0);
`ifdef WB_INSTRET_EN
        force dut.r_instret = '1;
        #1 release dut.r_instret;
        chk("instret_max", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b1, 1'b1, 5'd4, 1'b0, 3'd0, 3'd0, 64'd4, 64'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 3'd0, 64'd0, 64'd0);
        step();
        chk("instret_wrap", instret, 64'd0);
`endif

        // ---------------- randomized against reference model
        do_reset();
        m_v = 0; m_rw = 0; m_ld = 0; m_rd = 0; m_f3 = 0; m_a = 0;
        m_alu = 0; m_data = 0; m_cnt = 0;
        for (int unsigned n = 0; n < 400; n++) begin
            logic        r_v, r_rw, r_ld, r_fl, r_st, exp_ill, exp_we;
            logic [4:0]  r_rd;
            logic [2:0]  r_f3, r_a;
            logic [63:0] r_alu, r_data;
            r_v    = ($urandom_range(0, 9) != 0);
            r_rw   = ($urandom_range(0, 7) != 0);
            r_rd   = 5'($urandom_range(0, 31));
            r_ld   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_a    = 3'($urandom_range(0, 7));
            r_alu  = {$urandom, $urandom};
            r_data = {$urandom, $urandom};
            r_fl   = ($urandom_range(0, 9) == 0);
            r_st   = ($urandom_range(0, 7) == 0);
            drive(r_v, r_rw, r_rd, r_ld, r_f3, r_a, r_alu, r_data);
            flush = r_fl;
            stall = r_st;

            // model edge behaviour
            if (!r_fl && !r_st && m_v && !(m_ld && m_f3 == 3'd7))
                m_cnt = m_cnt + 64'd1;
            if (r_fl) begin
                m_v = 1'b0;
            end else if (!r_st) begin
                m_v = r_v; m_rw = r_rw; m_rd = r_rd; m_ld = r_ld;
                m_f3 = r_f3; m_a = r_a; m_alu = r_alu; m_data = r_data;
            end
            step();

            exp_ill = m_v && m_ld && (m_f3 == 3'd7);
            exp_we  = m_v && m_rw && (m_rd != 5'd0) && !exp_ill;
            chk("rnd_we", 64'(rf_we), 64'(exp_we));
            chk("rnd_fwd", 64'(fwd_valid), 64'(exp_we));
            chk("rnd_ill", 64'(wb_illegal), 64'(exp_ill));
            if (exp_we) begin
                chk("rnd_num", 64'(rf_write_num), 64'(m_rd));
                chk("rnd_val", rf_in_value, ref_result(m_ld, m_f3, m_a, m_alu, m_data));
            end
            chk("rnd_instret", instret, CNT_EN ? m_cnt : 64'd0);
        end
        flush = 1'b0;
        stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
